kmac_msg_arb: RTL
=================

Name: kmac_msg_arb

Overview:
- Arbitrates the KMAC message FIFO input between two requesters: software (register window) and application (key manager).
- A requester is granted for a whole message. The arbiter then sequences the flush, meaning the forwarded process pulse followed by the wait for the flush done indication.
- After the flush it waits for the core to finish absorbing, then issues the FIFO clear.
- Sits between the register/app front ends and the message FIFO's fifo_*/process/clear inputs.

Parameters:
- DataW, 64, data/mask width of each beat (equals message FIFO OutWidth).
- CntW, 16, width of the accepted-beat counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- sw_valid_i  in  1  SW beat valid
- sw_data_i  in  DataW  SW beat data
- sw_mask_i  in  DataW  SW beat mask
- sw_ready_o  out  1  SW beat accepted
- sw_process_i  in  1  SW end-of-message pulse
- sw_done_o  out  1  SW message complete pulse
- app_valid_i / app_data_i / app_mask_i / app_ready_o / app_process_i / app_done_o: same widths and meaning, for the APP requester.
- fifo_valid_o  out  1  beat valid to message FIFO
- fifo_data_o  out  DataW  beat data to message FIFO
- fifo_mask_o  out  DataW  beat mask to message FIFO
- fifo_ready_i  in  1  message FIFO ready
- fifo_process_o  out  1  process pulse to message FIFO
- fifo_process_done_i  in  1  message FIFO flush complete
- absorbed_i  in  1  core finished absorbing the message
- fifo_clear_o  out  4  mubi4 clear to message FIFO
- owner_o  out  2  current owner: 00 none, 01 SW, 10 APP
- beat_cnt_o  out  CntW  beats accepted in the current message
- err_o  out  1  protocol-violation pulse

Behaviour:
- Reset values (async on rst_i=1):
  - state=Idle; all ready/valid/done/process/err outputs 0.
  - fifo_clear_o=MuBi4False; owner_o=0; beat_cnt_o=0.
  - Round-robin pointer favours APP.
- Reset mid-message abandons the message: no clear is issued and no done is pulsed.
- States: Idle, OwnSw, OwnApp, Flush, Absorb, Clear.
- Idle:
  - A requester is pending if its valid_i or process_i is 1.
  - One pending: grant it.
  - Both pending: grant the round-robin favourite. The pointer then favours the other requester.
  - The grant is registered: Idle->OwnX takes 1 cycle.
  - No beat is accepted in Idle (all ready=0, fifo_valid_o=0).
- OwnX:
  - Combinational pass-through: fifo_valid/data/mask = X's inputs; X_ready_o = fifo_ready_i.
  - The non-owner's ready=0 and its inputs are ignored.
  - fifo_data_o and fifo_mask_o are 0 whenever fifo_valid_o=0.
  - Each fifo_valid_o&fifo_ready_i increments beat_cnt_o, saturating at all-ones.
- Process handling in OwnX:
  - X_process_i with X_valid_i=0: fifo_process_o=1 for exactly that cycle (combinational), then state->Flush.
  - X_process_i with X_valid_i=1: process ignored and err_o=1 for one cycle. The beat handshake proceeds normally.
- Flush:
  - All ready=0.
  - On fifo_process_done_i=1 -> Absorb.
- Absorb:
  - On absorbed_i=1 -> Clear.
  - absorbed_i in any other state is ignored.
- Clear:
  - For exactly one cycle: fifo_clear_o=MuBi4True and X_done_o=1.
  - beat_cnt_o is reset to 0 and the state returns to Idle.
  - owner_o remains X through Clear and becomes 0 in Idle.
- Errors, each giving err_o=1 for one cycle with no state effect:
  - process_i from the non-owner in OwnX.
  - process_i from any requester in Flush, Absorb or Clear.
  - fifo_process_done_i outside Flush.
- A process_i arriving in Idle counts as a request. The requester is granted, so its process_i must be re-asserted in OwnX; a zero-beat message is legal.
- Same-cycle process_i from both requesters in Idle is resolved by round-robin. The loser is not flagged.
- fifo_clear_o is never any value other than MuBi4True/MuBi4False.

Test Plan:
- SW-only message:
  - Stimulus: SW sends 3 beats (data 0x11..,0x22..,0x33.., mask all-ones) with fifo_ready_i=1, then sw_process_i; drive fifo_process_done_i 2 cycles later, absorbed_i 5 cycles later.
  - Required: beat_cnt_o=3; fifo_process_o is a single pulse; fifo_clear_o=MuBi4True for 1 cycle coincident with sw_done_o; owner_o returns to 0.
- Simultaneous request after reset:
  - Stimulus: sw_valid_i and app_valid_i both high in Idle.
  - Required: APP granted first (owner_o=10), sw_ready_o=0 throughout. After APP's Clear, SW is granted next.
- Backpressure:
  - Stimulus: fifo_ready_i toggles 1,0,0,1 while the owner holds valid.
  - Required: owner ready mirrors fifo_ready_i exactly; beat_cnt_o increments only on the 2 handshake cycles.
- Protocol errors:
  - Stimulus (a): the non-owner asserts process_i during OwnSw. Required: err_o pulses, state stays OwnSw.
  - Stimulus (b): the owner asserts process_i with valid_i=1. Required: err_o pulses, no fifo_process_o, the beat is accepted.
- Zero-length message:
  - Stimulus: app_process_i in Idle, then again in OwnApp.
  - Required: fifo_process_o on the second pulse only; beat_cnt_o=0 at done.
- Reset in Absorb:
  - Stimulus: assert rst_i while waiting for absorbed_i.
  - Required: all outputs at reset values, no clear or done pulse; a subsequent SW request is granted normally.

Source files
------------

// File: rtl/kmac_msg_arb.sv
// KMAC message FIFO input arbiter: grants SW or APP for a whole message,
// then sequences process/flush, waits for absorb, and issues the FIFO clear.
module kmac_msg_arb #(
  parameter int unsigned DataW = 64,
  parameter int unsigned CntW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sw_valid_i,
  input  logic [DataW-1:0] sw_data_i,
  input  logic [DataW-1:0] sw_mask_i,
  output logic             sw_ready_o,
  input  logic             sw_process_i,
  output logic             sw_done_o,
  input  logic             app_valid_i,
  input  logic [DataW-1:0] app_data_i,
  input  logic [DataW-1:0] app_mask_i,
  output logic             app_ready_o,
  input  logic             app_process_i,
  output logic             app_done_o,
  output logic             fifo_valid_o,
  output logic [DataW-1:0] fifo_data_o,
  output logic [DataW-1:0] fifo_mask_o,
  input  logic             fifo_ready_i,
  output logic             fifo_process_o,
  input  logic             fifo_process_done_i,
  input  logic             absorbed_i,
  output logic [3:0]       fifo_clear_o,
  output logic [1:0]       owner_o,
  output logic [CntW-1:0]  beat_cnt_o,
  output logic             err_o
);

  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;
  localparam logic [1:0] OwnNone    = 2'b00;
  localparam logic [1:0] OwnSwEnc   = 2'b01;
  localparam logic [1:0] OwnAppEnc  = 2'b10;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StOwnSw  = 3'd1,
    StOwnApp = 3'd2,
    StFlush  = 3'd3,
    StAbsorb = 3'd4,
    StClear  = 3'd5
  } state_e;

  state_e          r_state, w_state_d;
  logic            r_rr_app, w_rr_app_d;
  logic [1:0]      r_owner, w_owner_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_err, w_err;
  logic [3:0]      r_fifo_clear;
  logic            r_sw_done, r_app_done;

  logic             w_sel_sw;
  logic             w_own_valid, w_own_proc, w_other_proc, w_any_proc;
  logic [DataW-1:0] w_own_data, w_own_mask;
  logic             w_sw_pend, w_app_pend;

  // Owner-side view of the requester ports while streaming
  assign w_sel_sw     = (r_state == StOwnSw);
  assign w_own_valid  = w_sel_sw ? sw_valid_i   : app_valid_i;
  assign w_own_proc   = w_sel_sw ? sw_process_i : app_process_i;
  assign w_other_proc = w_sel_sw ? app_process_i : sw_process_i;
  assign w_own_data   = w_sel_sw ? sw_data_i    : app_data_i;
  assign w_own_mask   = w_sel_sw ? sw_mask_i    : app_mask_i;
  assign w_any_proc   = sw_process_i | app_process_i;
  assign w_sw_pend    = sw_valid_i  | sw_process_i;
  assign w_app_pend   = app_valid_i | app_process_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_rr_app     <= 1'b1;
      r_owner      <= OwnNone;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_fifo_clear <= MuBi4False;
      r_sw_done    <= 1'b0;
      r_app_done   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_rr_app     <= w_rr_app_d;
      r_owner      <= w_owner_d;
      r_cnt        <= w_cnt_d;
      r_err        <= w_err;
      r_fifo_clear <= (w_state_d == StClear) ? MuBi4True : MuBi4False;
      r_sw_done    <= (w_state_d == StClear) && (r_owner == OwnSwEnc);
      r_app_done   <= (w_state_d == StClear) && (r_owner == OwnAppEnc);
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_rr_app_d     = r_rr_app;
    w_owner_d      = r_owner;
    w_cnt_d        = r_cnt;
    w_err          = 1'b0;
    fifo_valid_o   = 1'b0;
    fifo_data_o    = '0;
    fifo_mask_o    = '0;
    sw_ready_o     = 1'b0;
    app_ready_o    = 1'b0;
    fifo_process_o = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_err = fifo_process_done_i;
        // Contention goes to the round-robin favourite, which then flips
        if (w_sw_pend && w_app_pend) begin
          w_rr_app_d = ~r_rr_app;
          w_state_d  = r_rr_app ? StOwnApp : StOwnSw;
          w_owner_d  = r_rr_app ? OwnAppEnc : OwnSwEnc;
        end else if (w_sw_pend) begin
          w_state_d = StOwnSw;
          w_owner_d = OwnSwEnc;
        end else if (w_app_pend) begin
          w_state_d = StOwnApp;
          w_owner_d = OwnAppEnc;
        end
      end
      StOwnSw, StOwnApp: begin
        fifo_valid_o = w_own_valid;
        fifo_data_o  = w_own_valid ? w_own_data : '0;
        fifo_mask_o  = w_own_valid ? w_own_mask : '0;
        sw_ready_o   = w_sel_sw  & fifo_ready_i;
        app_ready_o  = ~w_sel_sw & fifo_ready_i;
        if (w_own_valid && fifo_ready_i && (r_cnt != {CntW{1'b1}})) begin
          w_cnt_d = r_cnt + CntW'(1);
        end
        if (w_own_proc && !w_own_valid) begin
          fifo_process_o = 1'b1;
          w_state_d      = StFlush;
        end
        w_err = (w_own_proc & w_own_valid) | w_other_proc | fifo_process_done_i;
      end
      StFlush: begin
        w_err = w_any_proc;
        if (fifo_process_done_i) w_state_d = StAbsorb;
      end
      StAbsorb: begin
        w_err = w_any_proc | fifo_process_done_i;
        if (absorbed_i) w_state_d = StClear;
      end
      StClear: begin
        w_err     = w_any_proc | fifo_process_done_i;
        w_state_d = StIdle;
        w_owner_d = OwnNone;
        w_cnt_d   = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_owner_d = OwnNone;
        w_cnt_d   = '0;
      end
    endcase
  end

  assign fifo_clear_o = r_fifo_clear;
  assign owner_o      = r_owner;
  assign beat_cnt_o   = r_cnt;
  assign err_o        = r_err;
  assign sw_done_o    = r_sw_done;
  assign app_done_o   = r_app_done;

endmodule
